// File: rtl/sitcpxg_rx_buffer.sv
// Receive buffer behind the SiTCP 10GbE TCP RX port: owns the RX RAM and re-emits the stream as left-aligned 64-bit beats.
// Latency: a write shows up as RX_VALID 3 cycles later; at most one beat every 3 cycles, and a beat never crosses a 64-bit word.
// Backpressure: RX_READY low holds the beat in HOLD with data stable; the core sees progress only through USER_RX_RADR.
module sitcpxg_rx_buffer #(
    parameter int          ADDR_W  = 16,
    parameter logic [15:0] RX_SIZE = 16'd65520
) (
    input  logic        XGMII_CLOCK,
    input  logic        RSTn,
    output logic [15:0] USER_RX_SIZE,
    input  logic        USER_RX_CLR_ENB,
    output logic        USER_RX_CLR_REQ,
    output logic [15:0] USER_RX_RADR,
    input  logic [15:0] USER_RX_WADR,
    input  logic [7:0]  USER_RX_WENB,
    input  logic [63:0] USER_RX_WDAT,
    output logic [63:0] RX_DATA,
    output logic [3:0]  RX_BYTES,
    output logic        RX_VALID,
    input  logic        RX_READY,
    output logic [15:0] RX_AVAIL,
    output logic        RX_OVERFLOW
);

    localparam int WORD_W = ADDR_W - 3;
    localparam int DEPTH  = 1 << WORD_W;

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t              state_q, state_d;
    logic [63:0]         mem [DEPTH];
    logic [63:0]         ram_q;
    logic [ADDR_W-1:0]   rd_ptr, tail, avail_now, avail_q, wr_end_q;
    logic                wr_vld_q;
    logic [3:0]          n_q, n_next, room;
    logic [63:0]         beat_dat;
    logic                clr_armed_q, clr_take;
    logic                do_clear, do_issue, do_capture, do_accept;
    logic                unused_wadr;

    // Number of bytes up to and including the lowest enabled lane (lane 0 is the last byte of the word).
    function automatic logic [3:0] wr_len(input logic [7:0] en);
        logic [3:0] len;
        len = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (en[i]) len = 4'(8 - i);
        end
        return len;
    endfunction

    assign USER_RX_SIZE = RX_SIZE;
    assign USER_RX_RADR = 16'(rd_ptr);
    assign RX_AVAIL     = 16'(avail_q);
    assign unused_wadr  = ^USER_RX_WADR;

    assign avail_now = tail - rd_ptr;
    assign room      = 4'd8 - {1'b0, rd_ptr[2:0]};
    assign n_next    = (avail_now < ADDR_W'(room)) ? avail_now[3:0] : room;
    assign clr_take  = USER_RX_CLR_ENB && clr_armed_q;

    // Byte-enabled RAM with a registered read port on the read pointer's word.
    always_ff @(posedge XGMII_CLOCK) begin
        for (int i = 0; i < 8; i++) begin
            if (USER_RX_WENB[i])
                mem[USER_RX_WADR[ADDR_W-1:3]][8*i +: 8] <= USER_RX_WDAT[8*i +: 8];
        end
        ram_q <= mem[rd_ptr[ADDR_W-1:3]];
    end

    always_ff @(posedge XGMII_CLOCK or negedge RSTn) begin
        if (!RSTn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!clr_take && avail_now != '0) state_d = FETCH;
            FETCH:   state_d = HOLD;
            HOLD:    if (RX_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        do_clear   = 1'b0;
        do_issue   = 1'b0;
        do_capture = 1'b0;
        do_accept  = 1'b0;
        RX_VALID   = 1'b0;
        case (state_q)
            IDLE: begin
                do_clear = clr_take;
                do_issue = !clr_take && avail_now != '0;
            end
            FETCH:   do_capture = 1'b1;
            HOLD: begin
                RX_VALID  = 1'b1;
                do_accept = RX_READY;
            end
            default: ;
        endcase
    end

    // Align the first unread byte to [63:56] and blank everything past the beat length.
    always_comb begin
        beat_dat = ram_q << {rd_ptr[2:0], 3'b000};
        for (int i = 0; i < 8; i++) begin
            if (4'(i) >= n_q) beat_dat[56-8*i +: 8] = 8'h00;
        end
    end

    // The tail moves one cycle after the RAM write so a read of new bytes always sees written data.
    always_ff @(posedge XGMII_CLOCK or negedge RSTn) begin
        if (!RSTn) begin
            wr_vld_q <= 1'b0;
            wr_end_q <= '0;
            tail     <= '0;
        end else begin
            wr_vld_q <= |USER_RX_WENB;
            wr_end_q <= {USER_RX_WADR[ADDR_W-1:3], 3'b000} + ADDR_W'(wr_len(USER_RX_WENB));
            if (do_clear)      tail <= '0;
            else if (wr_vld_q) tail <= wr_end_q;
        end
    end

    always_ff @(posedge XGMII_CLOCK or negedge RSTn) begin
        if (!RSTn) begin
            rd_ptr   <= '0;
            n_q      <= '0;
            RX_DATA  <= '0;
            RX_BYTES <= '0;
        end else begin
            if (do_clear)       rd_ptr <= '0;
            else if (do_accept) rd_ptr <= rd_ptr + ADDR_W'(n_q);
            if (do_issue) n_q <= n_next;
            if (do_capture) begin
                RX_DATA  <= beat_dat;
                RX_BYTES <= n_q;
            end
        end
    end

    // Clear is edge-armed: one request per rising edge of CLR_ENB.
    always_ff @(posedge XGMII_CLOCK or negedge RSTn) begin
        if (!RSTn) begin
            clr_armed_q     <= 1'b1;
            USER_RX_CLR_REQ <= 1'b0;
            avail_q         <= '0;
            RX_OVERFLOW     <= 1'b0;
        end else begin
            if (!USER_RX_CLR_ENB) clr_armed_q <= 1'b1;
            else if (do_clear)    clr_armed_q <= 1'b0;
            USER_RX_CLR_REQ <= do_clear;
            avail_q         <= avail_now;
            if (RX_AVAIL > RX_SIZE) RX_OVERFLOW <= 1'b1;
        end
    end

endmodule
